// File: rtl/dg_return_stack.sv
// dg_return_stack -- parametrised return-address stack for the DG00xx
// 4-bit controller family.
//
// CALL pushes the PC, and RET/RETSK pops the return address back into the PC.
// Entry 0 is the top of the stack. The storage is a chain of DEPTH registered
// cells. Each cell takes its value from the entry above it (push shift), from
// the entry below it (pop shift), or keeps its own value.
//
// Parameters
//   AW        entry width (PU:PL address)
//   DEPTH     number of entries, 2..16
//   OVF_MODE  push-on-full policy: 0 = drop oldest (shift), 1 = reject push
//   LW        width of level / peek_idx, 2**LW > DEPTH
//
// Ports
//   clk, rst_n   clock (posedge) / asynchronous active-low reset
//   push, pop    CALL / RET command; both together = replace top
//   push_data    address to push
//   flush        empty the stack (highest priority, flags untouched)
//   clr_err      clear sticky overflow/underflow (a same-cycle event wins)
//   peek_idx     debug read index, 0 = top
//   top          entry 0 (registered)
//   peek_data    entry[peek_idx], 0 when out of range (combinational)
//   level        valid entry count 0..DEPTH (registered)
//   empty, full  level == 0 / level == DEPTH (registered)
//   overflow     sticky: push while full
//   underflow    sticky: pop while empty

module dg_rs_cell #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          sel_up,
   input  logic          sel_down,
   input  logic [AW-1:0] up,
   input  logic [AW-1:0] down,
   output logic [AW-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        q <= '0;
      else if (clr)      q <= '0;
      else if (sel_up)   q <= up;
      else if (sel_down) q <= down;
   end
endmodule

module dg_return_stack #(
   parameter int AW       = 10,
   parameter int DEPTH    = 5,
   parameter int OVF_MODE = 0,
   parameter int LW       = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   input  logic          flush,
   input  logic          clr_err,
   input  logic [LW-1:0] peek_idx,
   output logic [AW-1:0] top,
   output logic [AW-1:0] peek_data,
   output logic [LW-1:0] level,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underflow
);

   logic [DEPTH-1:0][AW-1:0] ent;

   logic [LW-1:0] level_q, level_nxt;
   logic          empty_q, full_q;
   logic          ovf_q, unf_q;

   logic do_clr, do_in, do_out, do_rep;
   logic ovf_evt, unf_evt;

   // Command decode in priority order: flush, replace, push, pop.
   // A push with an empty stack (even with a pop) is an ordinary push.
   always_comb begin
      do_clr    = 1'b0;
      do_in     = 1'b0;
      do_out    = 1'b0;
      do_rep    = 1'b0;
      ovf_evt   = 1'b0;
      unf_evt   = 1'b0;
      level_nxt = level_q;
      if (flush) begin
         do_clr    = 1'b1;
         level_nxt = '0;
      end else if (push && pop && !empty_q) begin
         do_rep = 1'b1;
      end else if (push) begin
         if (!full_q) begin
            do_in     = 1'b1;
            level_nxt = level_q + LW'(1);
         end else begin
            ovf_evt = 1'b1;
            // Legacy mode keeps shifting, so the bottom entry falls off.
            if (OVF_MODE == 0) do_in = 1'b1;
         end
      end else if (pop) begin
         // The entries shift even when the stack is empty. The bottom entry
         // replicates, which keeps top consistent with the old shift stack.
         do_out = 1'b1;
         if (!empty_q) level_nxt = level_q - LW'(1);
         else          unf_evt   = 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [AW-1:0] up, down;
      logic          sel_up;
      if (i == 0) begin : g_top
         assign up     = push_data;
         assign sel_up = do_in | do_rep;
      end else begin : g_mid
         assign up     = ent[i-1];
         assign sel_up = do_in;
      end
      if (i == DEPTH-1) begin : g_bot
         assign down = ent[i];
      end else begin : g_nbot
         assign down = ent[i+1];
      end
      dg_rs_cell #(.AW(AW)) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (do_clr),
         .sel_up   (sel_up),
         .sel_down (do_out),
         .up       (up),
         .down     (down),
         .q        (ent[i])
      );
   end

   // empty/full are registered from the next level so that they line up with
   // level and top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         level_q <= level_nxt;
         empty_q <= (level_nxt == '0);
         full_q  <= (level_nxt == LW'(DEPTH));
         ovf_q   <= ovf_evt | (ovf_q & ~clr_err);
         unf_q   <= unf_evt | (unf_q & ~clr_err);
      end
   end

   always_comb begin
      peek_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (peek_idx == LW'(i)) peek_data = ent[i];
   end

   assign top       = ent[0];
   assign level     = level_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_dg_return_stack.sv
// Testbench for dg_return_stack. It drives two instances with the same
// stimulus: OVF_MODE=0 (drop oldest) and OVF_MODE=1 (reject push). Each
// command's expected result comes from a list-level stack model and goes into
// a scoreboard queue. A monitor pops the queue and compares after each clock
// edge.
module tb_dg_return_stack;
   localparam int AW = 10, DEPTH = 5, LW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push = 0, pop = 0, flush = 0, clr_err = 0;
   logic [AW-1:0] push_data = '0;
   logic [LW-1:0] peek_idx = '0;

   logic [AW-1:0] top_o [2];
   logic [AW-1:0] peek_o [2];
   logic [LW-1:0] lvl_o [2];
   logic          emp_o [2], ful_o [2], ovf_o [2], unf_o [2];

   always #5 clk = ~clk;

   dg_return_stack #(.AW(AW), .DEPTH(DEPTH), .OVF_MODE(0), .LW(LW)) u_d0 (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
      .flush(flush), .clr_err(clr_err), .peek_idx(peek_idx),
      .top(top_o[0]), .peek_data(peek_o[0]), .level(lvl_o[0]), .empty(emp_o[0]),
      .full(ful_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

   dg_return_stack #(.AW(AW), .DEPTH(DEPTH), .OVF_MODE(1), .LW(LW)) u_d1 (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
      .flush(flush), .clr_err(clr_err), .peek_idx(peek_idx),
      .top(top_o[1]), .peek_data(peek_o[1]), .level(lvl_o[1]), .empty(emp_o[1]),
      .full(ful_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

   typedef struct {
      logic [AW-1:0] top, peek;
      logic [LW-1:0] lvl;
      logic          emp, ful, ovf, unf;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_pass = 0;

   // Reference model: a list of DEPTH slots, the count of valid slots, and
   // the two sticky flags for each policy.
   logic [AW-1:0] m_ent [2][DEPTH];
   int            m_lvl [2];
   bit            m_ovf [2], m_unf [2];

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < DEPTH; i++) m_ent[m][i] = '0;
         m_lvl[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      end
   endfunction

   function automatic void model_step(int m);
      bit oe = 0, ue = 0;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) m_ent[m][i] = '0;
         m_lvl[m] = 0;
      end else if (push && pop && m_lvl[m] > 0) begin
         m_ent[m][0] = push_data;
      end else if (push) begin
         if (m_lvl[m] == DEPTH) oe = 1;
         if (m_lvl[m] < DEPTH || m == 0) begin
            for (int i = DEPTH-1; i > 0; i--) m_ent[m][i] = m_ent[m][i-1];
            m_ent[m][0] = push_data;
            if (m_lvl[m] < DEPTH) m_lvl[m]++;
         end
      end else if (pop) begin
         for (int i = 0; i < DEPTH-1; i++) m_ent[m][i] = m_ent[m][i+1];
         if (m_lvl[m] > 0) m_lvl[m]--;
         else ue = 1;
      end
      m_ovf[m] = oe | (m_ovf[m] & !clr_err);
      m_unf[m] = ue | (m_unf[m] & !clr_err);
   endfunction

   function automatic exp_t model_exp(int m);
      exp_t e;
      e.top  = m_ent[m][0];
      e.peek = (int'(peek_idx) < DEPTH) ? m_ent[m][peek_idx] : '0;
      e.lvl  = LW'(m_lvl[m]);
      e.emp  = (m_lvl[m] == 0);
      e.ful  = (m_lvl[m] == DEPTH);
      e.ovf  = m_ovf[m];
      e.unf  = m_unf[m];
      return e;
   endfunction

   task automatic cmd(bit ps, bit pp, bit fl, bit ce, logic [AW-1:0] d, logic [LW-1:0] pk);
      @(negedge clk);
      push = ps; pop = pp; flush = fl; clr_err = ce; push_data = d; peek_idx = pk;
      for (int m = 0; m < 2; m++) begin
         model_step(m);
         sb.push_back(model_exp(m));
      end
   endtask

   task automatic idle();
      cmd(0, 0, 0, 0, '0, peek_idx);
   endtask

   task automatic check_reset_now(string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_top"}, d, top_o[d], 0);
         chk({nm, "_level"}, d, lvl_o[d], 0);
         chk({nm, "_empty"}, d, emp_o[d], 1);
         chk({nm, "_full"}, d, ful_o[d], 0);
         chk({nm, "_ovf"}, d, ovf_o[d], 0);
         chk({nm, "_unf"}, d, unf_o[d], 0);
      end
   endtask

   // Monitor: at each clock edge, take the expectation for the command that
   // the edge just executed and compare it once the outputs have settled.
   initial begin
      exp_t e [2];
      forever begin
         @(posedge clk);
         if (sb.size() >= 2) begin
            e[0] = sb.pop_front();
            e[1] = sb.pop_front();
            #1;
            for (int d = 0; d < 2; d++) begin
               chk("top", d, top_o[d], e[d].top);
               chk("peek", d, peek_o[d], e[d].peek);
               chk("level", d, lvl_o[d], e[d].lvl);
               chk("empty", d, emp_o[d], e[d].emp);
               chk("full", d, ful_o[d], e[d].ful);
               chk("overflow", d, ovf_o[d], e[d].ovf);
               chk("underflow", d, unf_o[d], e[d].unf);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #2 check_reset_now("por");
      @(negedge clk) rst_n = 1'b1;

      // Three pushes, then an asynchronous reset between clock edges.
      cmd(1, 0, 0, 0, 10'h011, 0);
      cmd(1, 0, 0, 0, 10'h022, 1);
      cmd(1, 0, 0, 0, 10'h033, 2);
      idle();
      @(posedge clk); #3;
      rst_n = 1'b0;
      model_reset();
      #1 check_reset_now("async_rst");
      @(negedge clk) rst_n = 1'b1;

      // Fill and drain.
      for (int i = 1; i <= 5; i++) cmd(1, 0, 0, 0, AW'(i), 4);
      for (int i = 0; i < 5; i++) cmd(0, 1, 0, 0, '0, 0);
      // Underflow and clear.
      cmd(0, 1, 0, 0, '0, 0);
      cmd(0, 0, 0, 1, '0, 0);
      cmd(0, 1, 0, 1, '0, 0);
      cmd(0, 0, 0, 1, '0, 0);

      // Overflow policy: full with 1..5, then push 0x3FF.
      for (int i = 1; i <= 5; i++) cmd(1, 0, 0, 0, AW'(i), 4);
      cmd(1, 0, 0, 0, 10'h3FF, 4);
      cmd(0, 0, 1, 1, '0, 0);

      // Replace, then flush together with push (flags stay).
      cmd(1, 0, 0, 0, 10'h010, 1);
      cmd(1, 0, 0, 0, 10'h020, 1);
      cmd(1, 1, 0, 0, 10'h155, 1);
      cmd(0, 1, 0, 0, '0, 1);
      cmd(0, 1, 0, 0, '0, 1);
      cmd(0, 1, 0, 0, '0, 1);
      cmd(1, 1, 1, 0, 10'h2AA, 0);
      // Push and pop together on an empty stack acts as a push.
      cmd(1, 1, 0, 0, 10'h0AB, 0);
      // Peek out of range.
      cmd(1, 0, 0, 0, 10'h0CD, 6);
      cmd(0, 0, 0, 0, '0, 7);
      cmd(0, 0, 0, 0, '0, 5);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         automatic bit fl = ($urandom_range(0, 99) < 3);
         automatic bit ce = ($urandom_range(0, 19) == 0);
         automatic bit ps = ($urandom_range(0, 99) < 50);
         automatic bit pp = ($urandom_range(0, 99) < 45);
         cmd(ps, pp, fl, ce, AW'($urandom), LW'($urandom_range(0, 7)));
      end
      idle();

      // Let the monitor drain the scoreboard, within a bounded time.
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dg_return_stack.md
Name: dg_return_stack

Overview:
- Parametrised hardware return-address stack for the DG00xx 4-bit controller family.
- Successor to the fixed 5-deep, 10-bit shift-register stack. Adds configurable width and depth, a selectable overflow policy, a fill level, and empty/full/sticky error flags.
- Adds a same-cycle replace operation, a flush, and a debug peek port.
- Sits beside the program counter: CALL pushes the current PC, RET/RETSK pops it into the PC, and the controller core reads the flags and level.

Parameters:
- AW, 10: entry width in bits (PU:PL address).
- DEPTH, 5: number of entries, 2..16.
- OVF_MODE, 0: push-on-full policy. 0 = drop the oldest entry (legacy shift behaviour). 1 = reject the push.
- LW, 3: width of level and peek_idx. Must satisfy 2^LW > DEPTH.

Ports:
- clk  in  1  system clock, posedge active
- rst_n  in  1  asynchronous active-low reset
- push  in  1  push push_data (CALL)
- pop  in  1  pop top entry (RET/RETSK)
- push_data  in  AW  address to push
- flush  in  1  empty the stack
- clr_err  in  1  clear the sticky error flags
- peek_idx  in  LW  debug read index (0 = top)
- top  out  AW  entry 0, the current return address
- peek_data  out  AW  entry[peek_idx]; 0 when peek_idx >= DEPTH
- level  out  LW  number of valid entries, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overflow  out  1  sticky: a push occurred while full
- underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Storage: entry[0..DEPTH-1], registered. Entry 0 is the top. All updates occur on posedge clk.
- Reset (asynchronous, rst_n=0): all entries, level, overflow and underflow go to 0. Therefore top=0, empty=1, full=0.
- Outputs: top, level, empty and full come directly from registers and change one cycle after the command.
- peek_data is a combinational read of the current registers.
- Operations are decoded in priority order:
  1. flush: level <= 0 and all entries <= 0. Push and pop are ignored that cycle. No flag is set.
  2. push & pop, level > 0 (replace): entry[0] <= push_data; the other entries and level are unchanged; no flag.
  3. push & pop, level == 0: behaves as a push; level becomes 1; no underflow.
  4. push only, not full:
     - entry[i+1] <= entry[i]; entry[0] <= push_data; level+1.
  5. push only, full, OVF_MODE=0:
     - Shift as for a push; the oldest entry is lost; level stays DEPTH.
     - overflow <= 1.
  6. push only, full, OVF_MODE=1:
     - Entries and level are unchanged.
     - overflow <= 1.
  7. pop only, level > 0:
     - entry[i] <= entry[i+1]; entry[DEPTH-1] keeps its value (bottom replicates, legacy); level-1.
  8. pop only, level == 0:
     - The entries still shift with bottom replication, so top stays stale-consistent with the legacy stack.
     - level stays 0; underflow <= 1.
- Sticky flags: clr_err clears overflow and underflow. If an error event occurs in the same cycle as clr_err, the set wins. flush does not clear the flags.
- level never exceeds DEPTH and never wraps below 0.
- push_data is sampled only at the clock edge where push is accepted.

Test Plan:
- Reset: assert rst_n=0 mid-stream after 3 pushes, with no clock edge needed (asynchronous) -> top=0, level=0, empty=1, overflow=0, underflow=0.
- Fill and drain (DEPTH=5, AW=10):
  - Push 0x001, 0x002, 0x003, 0x004, 0x005 -> level=5, full=1, top=0x005, peek_idx=4 gives 0x001.
  - Then pop 5 times -> tops 0x004, 0x003, 0x002, 0x001, then empty=1 with top=0x001.
- Overflow policy:
  - OVF_MODE=0, full with 0x001..0x005, push 0x3FF -> top=0x3FF, peek[4]=0x002, level=5, overflow=1.
  - OVF_MODE=1, same stimulus -> top=0x005, peek[4]=0x001, overflow=1.
- Underflow and clear:
  - Pop on an empty stack -> level=0, underflow=1.
  - clr_err alone -> underflow=0.
  - clr_err together with a pop on empty -> underflow stays 1.
- Replace and flush:
  - level=2 (tops 0x010, 0x020), push and pop together with 0x155 -> top=0x155, peek[1]=0x010, level=2.
  - Then flush together with push -> level=0, top=0, flags unchanged.
- Peek bounds: peek_idx=6 with DEPTH=5 -> peek_data=0.
